change_dispenser: RTL and testbench

Drives the coin hopper that pays out change. It accepts a change amount from the vending controller over a `req` interface and breaks it down greedily into 10/5/2/1 coins. For each coin it fires one hopper eject pulse and waits for the hopper's coin-sensed confirmation. It keeps a per-denomination coin inventory and reports a shortfall (not enough coins) or a jam (no confirmation within the timeout).

---
 rtl/change_dispenser.sv | 199 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin hopper driver: splits a change amount greedily into 10/5/2/1 coins,
// pulses the hopper per coin, waits for the sense confirmation and tracks inventory.
module change_dispenser #(
    parameter int AMT_W        = 8,
    parameter int INV_W        = 6,
    parameter int INV_INIT     = 20,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             sense,
    input  logic             refill_en,
    input  logic [1:0]       refill_sel,
    input  logic [INV_W-1:0] refill_cnt,
    output logic [3:0]       eject,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic             jam,
    output logic [AMT_W-1:0] remaining,
    output logic [3:0]       empty
);

    localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (TIMEOUT > MAX_PG) ? TIMEOUT : MAX_PG;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_WAIT   = 3'd3,
        S_GAP    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t             state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic [1:0]         sel_r, sel_nx_s, pick_s;
    logic               pick_ok_s;
    logic [INV_W-1:0]   inv_r [4];
    logic [INV_W-1:0]   inv_nx_s [4];
    logic [3:0]         empty_r, empty_nx_s;
    logic [3:0]         eject_r, eject_nx_s;
    logic               busy_r, busy_nx_s, done_r, done_nx_s;
    logic               short_r, short_nx_s, jam_r, jam_nx_s;
    logic [AMT_W-1:0]   remaining_r, remaining_nx_s;
    logic               sense_ok_s, timeout_s;

    // Index 0..3 maps to coin values 1, 2, 5, 10.
    function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] idx);
        case (idx)
            2'd0:    coin_val = AMT_W'(4'd1);
            2'd1:    coin_val = AMT_W'(4'd2);
            2'd2:    coin_val = AMT_W'(4'd5);
            2'd3:    coin_val = AMT_W'(4'd10);
            default: coin_val = AMT_W'(4'd0);
        endcase
    endfunction

    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                 input logic [INV_W-1:0] b);
        logic [INV_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[INV_W]) sat_add = '1;
        else            sat_add = sum[INV_W-1:0];
    endfunction

    assign sense_ok_s = (state_r == S_WAIT) && sense;
    assign timeout_s  = (state_r == S_WAIT) && !sense && (cnt_r == CNT_W'(TIMEOUT - 1));

    // Greedy pick: the highest-indexed coin that fits and is in stock wins.
    always_comb begin
        pick_ok_s = 1'b0;
        pick_s    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if ((coin_val(2'(i)) <= remaining_r) && (inv_r[i] != '0)) begin
                pick_ok_s = 1'b1;
                pick_s    = 2'(i);
            end else begin
                pick_s    = pick_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= next_state_s;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req) next_state_s = S_SELECT;
                else     next_state_s = S_IDLE;
            end
            S_SELECT: begin
                if (remaining_r == '0) next_state_s = S_FINISH;
                else if (pick_ok_s)    next_state_s = S_EJECT;
                else                   next_state_s = S_FINISH;
            end
            S_EJECT: begin
                if (cnt_r == CNT_W'(PULSE_CYCLES - 1)) next_state_s = S_WAIT;
                else                                   next_state_s = S_EJECT;
            end
            S_WAIT: begin
                if (sense)          next_state_s = S_GAP;
                else if (timeout_s) next_state_s = S_FINISH;
                else                next_state_s = S_WAIT;
            end
            S_GAP: begin
                if (cnt_r == CNT_W'(GAP_CYCLES - 1)) next_state_s = S_SELECT;
                else                                 next_state_s = S_GAP;
            end
            S_FINISH: next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // Output / datapath next values; outputs follow the state being entered.
    always_comb begin
        if (state_r == S_SELECT) sel_nx_s = pick_s;
        else                     sel_nx_s = sel_r;

        if (next_state_s == S_EJECT) eject_nx_s = 4'b0001 << sel_nx_s;
        else                         eject_nx_s = 4'b0000;

        busy_nx_s = (next_state_s != S_IDLE);
        done_nx_s = (next_state_s == S_FINISH);

        if ((next_state_s != state_r) || (state_r == S_IDLE)) cnt_nx_s = '0;
        else                                                  cnt_nx_s = cnt_r + CNT_W'(1);

        if ((state_r == S_IDLE) && req) remaining_nx_s = amount;
        else if (sense_ok_s)            remaining_nx_s = remaining_r - coin_val(sel_r);
        else                            remaining_nx_s = remaining_r;

        if ((state_r == S_IDLE) && req) short_nx_s = 1'b0;
        else if ((state_r == S_SELECT) && (remaining_r != '0) && !pick_ok_s) short_nx_s = 1'b1;
        else                            short_nx_s = short_r;

        if ((state_r == S_IDLE) && req) jam_nx_s = 1'b0;
        else if (timeout_s)             jam_nx_s = 1'b1;
        else                            jam_nx_s = jam_r;

        for (int i = 0; i < 4; i++) begin
            if ((state_r == S_IDLE) && refill_en && (refill_sel == 2'(i)))
                inv_nx_s[i] = sat_add(inv_r[i], refill_cnt);
            else if (sense_ok_s && (sel_r == 2'(i)))
                inv_nx_s[i] = inv_r[i] - INV_W'(1);
            else
                inv_nx_s[i] = inv_r[i];
            empty_nx_s[i] = (inv_nx_s[i] == '0);
        end
    end

    // Registered outputs, inventory and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= '0;
            sel_r       <= 2'd0;
            eject_r     <= 4'b0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            short_r     <= 1'b0;
            jam_r       <= 1'b0;
            remaining_r <= '0;
            for (int i = 0; i < 4; i++) inv_r[i] <= INV_W'(INV_INIT);
            empty_r     <= {4{INV_INIT == 0}};
        end else begin
            cnt_r       <= cnt_nx_s;
            sel_r       <= sel_nx_s;
            eject_r     <= eject_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
            short_r     <= short_nx_s;
            jam_r       <= jam_nx_s;
            remaining_r <= remaining_nx_s;
            for (int i = 0; i < 4; i++) inv_r[i] <= inv_nx_s[i];
            empty_r     <= empty_nx_s;
        end
    end

    assign eject     = eject_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign short     = short_r;
    assign jam       = jam_r;
    assign remaining = remaining_r;
    assign empty     = empty_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, multi-cycle corner
// sequences and randomized transactions against a greedy change model.
module tb_change_dispenser;

    localparam int AMT_W = 8, INV_W = 6, INV_INIT = 20, P = 4, G = 2, T = 64;

    logic             clk = 1'b0;
    logic             rst, req, sense, refill_en;
    logic [AMT_W-1:0] amount;
    logic [1:0]       refill_sel;
    logic [INV_W-1:0] refill_cnt;
    logic [3:0]       eject, empty;
    logic             busy, done, short, jam;
    logic [AMT_W-1:0] remaining;

    change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .INV_INIT(INV_INIT),
                       .PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .amount(amount), .sense(sense),
        .refill_en(refill_en), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
        .eject(eject), .busy(busy), .done(done), .short(short), .jam(jam),
        .remaining(remaining), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int val [4] = '{1, 2, 5, 10};
    int m_inv [4];
    int m_rem, m_paid, m_done_cyc;
    bit m_short, m_jam;
    int exp_q[$], got_q[$];
    int got_done_cnt, got_done_cyc, got_rem, got_short, got_jam;

    typedef struct {
        int amt; int dly; int coins; int rem; int sh; int jm;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Greedy change model; dly < 0 means the hopper never confirms.
    task automatic model_txn(input int amt, input int dly, input bit ren,
                             input int rsel, input int rcnt);
        int pick;
        if (ren) m_inv[rsel] = (m_inv[rsel] + rcnt > 63) ? 63 : m_inv[rsel] + rcnt;
        m_rem = amt; m_short = 0; m_jam = 0; m_paid = 0;
        exp_q.delete();
        while (m_rem > 0 && !m_short && !m_jam) begin
            pick = -1;
            for (int i = 0; i < 4; i++)
                if (val[i] <= m_rem && m_inv[i] > 0) pick = i;
            if (pick < 0) m_short = 1;
            else begin
                exp_q.push_back(1 << pick);
                if (dly < 0) m_jam = 1;
                else begin
                    m_rem -= val[pick];
                    m_inv[pick]--;
                    m_paid++;
                end
            end
        end
        m_done_cyc = 1 + m_paid * (1 + P + dly + 1 + G) + (m_jam ? 1 + P + T : 1);
    endtask

    task automatic check_inv(input string nm);
        logic [3:0] exp_empty;
        for (int i = 0; i < 4; i++) exp_empty[i] = (m_inv[i] == 0);
        chk({nm, "_empty"}, empty, exp_empty);
        for (int i = 0; i < 4; i++) chk({nm, "_inv"}, dut.inv_r[i], m_inv[i]);
    endtask

    // Starts at #1 after an edge; req is sampled at the next edge (cycle 0).
    task automatic run_txn(input string nm, input int amt, input int dly, input bit ren,
                           input int rsel, input int rcnt, input bit poke);
        int cyc, plen, cd;
        logic [3:0] prev;
        bit fin;
        model_txn(amt, dly, ren, rsel, rcnt);
        got_q.delete(); got_done_cnt = 0; got_done_cyc = -1;
        req = 1'b1; amount = AMT_W'(amt);
        refill_en = ren; refill_sel = 2'(rsel); refill_cnt = INV_W'(rcnt);
        tick();
        req = 1'b0; refill_en = 1'b0;
        cyc = 1; prev = 4'b0; plen = 0; cd = -1; fin = 0;
        chk({nm, "_busy_c1"}, busy, 1);
        while (!fin) begin
            if (eject != 4'b0) begin
                chk({nm, "_onehot"}, $onehot(eject), 1);
                if (prev == 4'b0) begin
                    got_q.push_back(int'(eject));
                    plen = 1;
                    if (got_q.size() == 1) chk({nm, "_first_eject_cyc"}, cyc, 2);
                end else plen++;
            end else if (prev != 4'b0) begin
                chk({nm, "_pulse_width"}, plen, P);
                cd = dly;
            end
            prev = eject;
            if (cd == 0) begin sense = 1'b1; cd = -1; end
            else begin sense = 1'b0; if (cd > 0) cd--; end
            if (poke && cyc == 3) begin
                req = 1'b1; amount = AMT_W'(7);
                refill_en = 1'b1; refill_sel = 2'd3; refill_cnt = INV_W'(5);
            end else begin
                req = 1'b0; refill_en = 1'b0;
            end
            if (done) begin
                got_done_cnt++;
                if (got_done_cnt == 1) begin
                    got_done_cyc = cyc; got_rem = int'(remaining);
                    got_short = int'(short); got_jam = int'(jam);
                end
            end
            if (got_done_cnt > 0 && !busy) begin
                chk({nm, "_busy_fall"}, cyc, got_done_cyc + 1);
                fin = 1;
            end else if (cyc > 3000) begin
                n_cmp++; n_err++;
                $display("FAIL %s_timeout: got no done after %0d cycles, expected done", nm, cyc);
                fin = 1;
            end
            tick();
            cyc++;
        end
        sense = 1'b0; req = 1'b0; refill_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_no_extra_done"}, done, 0);
            tick();
        end
        chk({nm, "_coin_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({nm, "_coin_seq"}, got_q[i], exp_q[i]);
        chk({nm, "_done_count"}, got_done_cnt, 1);
        chk({nm, "_done_cyc"}, got_done_cyc, m_done_cyc);
        chk({nm, "_remaining"}, got_rem, m_rem);
        chk({nm, "_short"}, got_short, m_short);
        chk({nm, "_jam"}, got_jam, m_jam);
        check_inv(nm);
    endtask

    initial begin
        int amt, dly;
        bit ren;
        rst = 1'b1; req = 1'b0; sense = 1'b0; refill_en = 1'b0;
        amount = '0; refill_sel = 2'd0; refill_cnt = '0;
        for (int i = 0; i < 4; i++) m_inv[i] = INV_INIT;
        #1;
        chk("rst_eject", eject, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_short", short, 0);
        chk("rst_jam", jam, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_empty", empty, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed table from full inventory: {amount, sense delay, coins, remaining, short, jam}.
        vecs[0] = '{18, 3, 4, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0, 0};
        vecs[2] = '{10, -1, 1, 10, 0, 1};
        vecs[3] = '{27, 0, 4, 0, 0, 0};
        vecs[4] = '{1, 1, 1, 0, 0, 0};
        for (int v = 0; v < 5; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].amt, vecs[v].dly, 0, 0, 0, 0);
            chk($sformatf("vec%0d_tbl_coins", v), got_q.size(), vecs[v].coins);
            chk($sformatf("vec%0d_tbl_rem", v), got_rem, vecs[v].rem);
            chk($sformatf("vec%0d_tbl_short", v), got_short, vecs[v].sh);
            chk($sformatf("vec%0d_tbl_jam", v), got_jam, vecs[v].jm);
            if (v == 0) begin
                chk("vec0_seq_10", got_q[0], 8);
                chk("vec0_seq_1", got_q[3], 1);
            end
        end

        // Empty the 5-coin stock, then 8 must be paid as four 2-coins.
        while (m_inv[2] > 0) run_txn("drain5", 5, 0, 0, 0, 0, 0);
        run_txn("eight", 8, 2, 0, 0, 0, 0);
        chk("eight_coins", got_q.size(), 4);
        chk("eight_empty5", empty[2], 1);

        // No 1-coins and a single 2-coin: 3 leaves 1 unpaid.
        while (m_inv[0] > 0) run_txn("drain1", 1, 0, 0, 0, 0, 0);
        while (m_inv[1] > 1) run_txn("drain2", 2, 0, 0, 0, 0, 0);
        run_txn("shortfall", 3, 0, 0, 0, 0, 0);
        chk("shortfall_short", got_short, 1);
        chk("shortfall_rem", got_rem, 1);
        chk("shortfall_empty2", empty[1], 1);

        // Reset in the second EJECT cycle.
        req = 1'b1; amount = AMT_W'(10);
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("mid_eject_before_rst", eject, 8);
        rst = 1'b1;
        #1;
        chk("mid_rst_eject", eject, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_remaining", remaining, 0);
        chk("mid_rst_empty", empty, 0);
        for (int i = 0; i < 4; i++) m_inv[i] = INV_INIT;
        tick();
        rst = 1'b0;
        tick();
        check_inv("after_rst");
        run_txn("after_rst_five", 5, 1, 0, 0, 0, 0);

        // Idle refill saturates; refill and req while busy are ignored.
        refill_en = 1'b1; refill_sel = 2'd0; refill_cnt = INV_W'(63);
        tick();
        refill_en = 1'b0;
        m_inv[0] = 63;
        tick();
        chk("refill_sat", dut.inv_r[0], 63);
        run_txn("busy_poke", 4, 0, 0, 0, 0, 1);

        // Randomized transactions, sometimes with a simultaneous refill.
        for (int r = 0; r < 40; r++) begin
            amt = $urandom_range(0, 45);
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            ren = ($urandom_range(0, 2) == 0);
            run_txn($sformatf("rnd%0d", r), amt, dly, ren,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
